enoc_switch_allocator: RTL and testbench

//   Shares the five router output ports [c,n,e,s,w] among the five input ports of one ENoC router.

---
 rtl/enoc_pkg.sv | 29 ++
 rtl/enoc_switch_allocator_if.sv | 32 +++
 rtl/enoc_rr_arbiter.sv | 37 +++
 rtl/enoc_switch_allocator.sv | 133 +++++++++++++
 tb/tb_enoc_switch_allocator.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enoc_pkg.sv
// Shared definitions for the ENoC router switch allocator.
//   N_PORTS        number of router ports (inputs = outputs)
//   PTR_W          width of a port index
//   PORT_C..PORT_W port index constants, order c=0, n=1, e=2, s=3, w=4
//   alloc_state_t  per-output allocation state
//   port_vec_t     one bit per port, bit 0 = c
//   next_port()    cyclic successor of a port index
package enoc_pkg;

  localparam int unsigned N_PORTS = 5;
  localparam int unsigned PTR_W   = $clog2(N_PORTS);

  localparam int unsigned PORT_C = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_W = 4;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_t;

  typedef logic [0:N_PORTS-1] port_vec_t;
  typedef logic [PTR_W-1:0]   port_idx_t;

  // Successor index with wrap from the last port back to port 0.
  function automatic port_idx_t next_port(input port_idx_t idx);
    return (idx == port_idx_t'(N_PORTS - 1)) ? {PTR_W{1'b0}} : idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/enoc_switch_allocator_if.sv
// Request/grant bundle between the input buffers, route calculators,
// crossbar and the switch allocator.
//   i_val          input i has a valid flit at its buffer head
//   i_output_req   [i*N+o] input i requests output o (one-hot per input)
//   i_tail         head flit of input i is a tail
//   i_en           output o can accept a flit this cycle
//   o_output_sel   [o*N+i] crossbar connects input i to output o
//   o_input_grant  input i's flit transfers this cycle
//   o_output_val   output o carries a valid flit this cycle
// master: requesting side; slave: the allocator.
interface enoc_switch_allocator_if;
  import enoc_pkg::*;

  port_vec_t                  i_val;
  logic [0:N_PORTS*N_PORTS-1] i_output_req;
  port_vec_t                  i_tail;
  port_vec_t                  i_en;
  logic [0:N_PORTS*N_PORTS-1] o_output_sel;
  port_vec_t                  o_input_grant;
  port_vec_t                  o_output_val;

  modport master (
    output i_val, i_output_req, i_tail, i_en,
    input  o_output_sel, o_input_grant, o_output_val
  );

  modport slave (
    input  i_val, i_output_req, i_tail, i_en,
    output o_output_sel, o_input_grant, o_output_val
  );

endinterface

// File: rtl/enoc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request found by
// searching cyclically upward from ptr.
//   req    request vector, bit 0 = port 0
//   ptr    index where the search starts
//   grant  one-hot grant (all zero when nothing requests)
//   idx    index of the granted request
//   any    at least one request is set
module enoc_rr_arbiter #(
  parameter  int unsigned N     = 5,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [0:N-1]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [0:N-1]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Cyclic first-set search: the first hit after ptr wins, later hits are masked.
  always_comb begin
    int unsigned cand;
    logic        hit;
    cand  = 32'd0;
    hit   = 1'b0;
    grant = {N{1'b0}};
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand        = (32'(ptr) + k) % N;
      hit         = req[cand] & ~any;
      grant[cand] = hit;
      idx         = hit ? IDX_W'(cand) : idx;
      any         = any | hit;
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// Switch allocator of one ENoC router. Each output port runs its own
// round-robin arbiter and a wormhole lock held from head grant until the
// tail flit transfers. Grants are combinational (zero-cycle latency);
// arbitration state updates on the clock edge.
//   clk    router clock
//   reset  asynchronous, active-high; forces every output low while high
//   bus    request/grant bundle (slave side)
module enoc_switch_allocator
  import enoc_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  enoc_switch_allocator_if.slave bus
);

  localparam int unsigned N = N_PORTS;

  port_vec_t                  sel_row_s [N];
  logic                       xfer_s    [N];
  logic [0:N_PORTS*N_PORTS-1] out_sel_s;
  port_vec_t                  out_grant_s;
  port_vec_t                  out_val_s;

  for (genvar o = 0; o < N; o++) begin : g_out
    alloc_state_t state_r, state_nxt_s;
    port_idx_t    owner_r, owner_nxt_s;
    port_idx_t    ptr_r, ptr_nxt_s;
    port_vec_t    req_s, arb_grant_s, owner_oh_s, row_s;
    port_idx_t    arb_idx_s;
    logic         arb_any_s, sel_any_s, xfer_o_s;

    // Request set for this output: valid inputs whose route points here.
    always_comb begin
      req_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        req_s[i] = bus.i_val[i] & bus.i_output_req[i*N+o];
      end
    end

    enoc_rr_arbiter #(.N(N)) u_arb (
      .req   (req_s),
      .ptr   (ptr_r),
      .grant (arb_grant_s),
      .idx   (arb_idx_s),
      .any   (arb_any_s)
    );

    // Selection: arbiter winner when idle; when locked only the owner, and only while it requests.
    always_comb begin
      owner_oh_s          = {N{1'b0}};
      owner_oh_s[owner_r] = 1'b1;
      sel_any_s           = 1'b0;
      row_s               = {N{1'b0}};
      if (state_r == LOCKED) begin
        sel_any_s = req_s[owner_r];
        row_s     = req_s[owner_r] ? owner_oh_s : {N{1'b0}};
      end else begin
        sel_any_s = arb_any_s;
        row_s     = arb_grant_s;
      end
      xfer_o_s = sel_any_s & bus.i_en[o];
    end

    // Next state: a single-flit transfer from idle only advances ptr; any other winner
    // takes the lock even without a transfer so the selection holds while i_en is low.
    always_comb begin
      state_nxt_s = state_r;
      owner_nxt_s = owner_r;
      ptr_nxt_s   = ptr_r;
      case (state_r)
        IDLE: begin
          if (arb_any_s && bus.i_tail[arb_idx_s] && bus.i_en[o]) begin
            ptr_nxt_s = next_port(arb_idx_s);
          end else if (arb_any_s) begin
            state_nxt_s = LOCKED;
            owner_nxt_s = arb_idx_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOCKED: begin
          if (xfer_o_s && bus.i_tail[owner_r]) begin
            state_nxt_s = IDLE;
            ptr_nxt_s   = next_port(owner_r);
          end else begin
            state_nxt_s = LOCKED;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          owner_nxt_s = {PTR_W{1'b0}};
          ptr_nxt_s   = {PTR_W{1'b0}};
        end
      endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_r <= IDLE;
        owner_r <= {PTR_W{1'b0}};
        ptr_r   <= {PTR_W{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        owner_r <= owner_nxt_s;
        ptr_r   <= ptr_nxt_s;
      end
    end

    assign sel_row_s[o] = row_s;
    assign xfer_s[o]    = xfer_o_s;
  end

  // Crossbar selects, read enables and output valids; all held low during reset.
  // Each input requests one output, so at most one term of the grant OR is set.
  always_comb begin
    out_sel_s   = {(N_PORTS*N_PORTS){1'b0}};
    out_grant_s = {N{1'b0}};
    out_val_s   = {N{1'b0}};
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        out_sel_s[o*N+i] = sel_row_s[o][i] & ~reset;
        out_grant_s[i]   = out_grant_s[i] | (sel_row_s[o][i] & xfer_s[o] & ~reset);
      end
      out_val_s[o] = xfer_s[o] & ~reset;
    end
  end

  assign bus.o_output_sel  = out_sel_s;
  assign bus.o_input_grant = out_grant_s;
  assign bus.o_output_val  = out_val_s;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Self-checking bench for enoc_switch_allocator: directed scenarios plus a
// randomized run, all compared against a behavioural per-output model.
module tb_enoc_switch_allocator;
  import enoc_pkg::*;

  localparam int N = N_PORTS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enoc_switch_allocator_if bus();

  enoc_switch_allocator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state per output: locked flag, owner, round-robin pointer; m_sel is this cycle's pick.
  int m_locked [N];
  int m_owner  [N];
  int m_ptr    [N];
  int m_sel    [N];
  logic [0:N*N-1] exp_sel;
  port_vec_t      exp_grant;
  port_vec_t      exp_val;

  // Stimulus legality: every valid input routes to exactly one output.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.i_val[i]) assert ($onehot(bus.i_output_req[i*N +: N])) else $error("illegal multi-output request from input %0d", i);
    end
  end

  function automatic bit req_of(int i, int o);
    return bus.i_val[i] && bus.i_output_req[i*N+o];
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_sel[o] = -1;
    end
  endtask

  task automatic model_eval();
    for (int o = 0; o < N; o++) begin
      m_sel[o] = -1;
      if (m_locked[o] != 0) begin
        if (req_of(m_owner[o], o)) m_sel[o] = m_owner[o];
      end else begin
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr[o] + k) % N;
          if (m_sel[o] < 0 && req_of(i, o)) m_sel[o] = i;
        end
      end
    end
    exp_sel = '0; exp_grant = '0; exp_val = '0;
    if (!reset) begin
      for (int o = 0; o < N; o++) begin
        if (m_sel[o] >= 0) begin
          exp_sel[o*N + m_sel[o]] = 1'b1;
          if (bus.i_en[o]) begin
            exp_val[o] = 1'b1;
            exp_grant[m_sel[o]] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < N; o++) begin
      if (m_sel[o] >= 0) begin
        int w = m_sel[o];
        if (m_locked[o] == 0) begin
          if (bus.i_tail[w] && bus.i_en[o]) m_ptr[o] = (w + 1) % N;
          else begin m_locked[o] = 1; m_owner[o] = w; end
        end else if (bus.i_en[o] && bus.i_tail[w]) begin
          m_locked[o] = 0; m_ptr[o] = (w + 1) % N;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    bus.i_val = '0; bus.i_output_req = '0; bus.i_tail = '0; bus.i_en = '0;
  endtask

  task automatic drive(int i, int d, bit t);
    bus.i_val[i] = 1'b1;
    for (int k = 0; k < N; k++) bus.i_output_req[i*N+k] = (k == d);
    bus.i_tail[i] = t;
  endtask

  task automatic idle_in(int i);
    bus.i_val[i] = 1'b0;
    for (int k = 0; k < N; k++) bus.i_output_req[i*N+k] = 1'b0;
    bus.i_tail[i] = 1'b0;
  endtask

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    drive(PORT_C, PORT_E, 1'b1);
    drive(PORT_S, PORT_S, 1'b0);
    bus.i_en = '1;
    #3;
    checks++;
    if ({bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs sel=%h grant=%b val=%b required all zero", bus.o_output_sel, bus.o_input_grant, bus.o_output_val);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_inputs();
    settle();
    checks++;
    if ({bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
      errors++;
      $display("FAIL reset_idle sel=%h grant=%b val=%b exp sel=%h grant=%b val=%b", bus.o_output_sel, bus.o_input_grant, bus.o_output_val, exp_sel, exp_grant, exp_val);
    end
    advance();
  endtask

  task automatic test_single();
    do_reset();
    drive(PORT_N, PORT_E, 1'b1);
    bus.i_en[PORT_E] = 1'b1;
    settle();
    checks++;
    if ({bus.o_output_sel[PORT_E*N +: N], bus.o_input_grant, bus.o_output_val} !== 15'b01000_01000_00100) begin
      errors++;
      $display("FAIL single_n_to_e sel_e=%b grant=%b val=%b required 01000 01000 00100", bus.o_output_sel[PORT_E*N +: N], bus.o_input_grant, bus.o_output_val);
    end
    advance();
    clear_inputs();
    // ptr_e should now be 2: with n and s both requesting e, s wins.
    drive(PORT_N, PORT_E, 1'b1);
    drive(PORT_S, PORT_E, 1'b1);
    bus.i_en[PORT_E] = 1'b1;
    settle();
    checks++;
    if (bus.o_input_grant !== 5'b00010 || bus.o_input_grant !== exp_grant) begin
      errors++;
      $display("FAIL single_ptr_e grant=%b required 00010 (model %b)", bus.o_input_grant, exp_grant);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int        order [6] = '{PORT_C, PORT_S, PORT_W, PORT_C, PORT_S, PORT_W};
    port_vec_t want;
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(PORT_C, PORT_N, 1'b1);
      drive(PORT_S, PORT_N, 1'b1);
      drive(PORT_W, PORT_N, 1'b1);
      bus.i_en[PORT_N] = 1'b1;
      settle();
      want = '0;
      want[order[cyc]] = 1'b1;
      checks++;
      if (bus.o_input_grant !== want || {bus.o_output_sel, bus.o_output_val} !== {exp_sel, exp_val}) begin
        errors++;
        $display("FAIL rr_c%0d grant=%b required %b sel=%h exp %h", cyc, bus.o_input_grant, want, bus.o_output_sel, exp_sel);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_wormhole();
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.i_en[PORT_W] = 1'b1;
      if (cyc <= 3) drive(PORT_E, PORT_W, cyc == 3); else idle_in(PORT_E);
      if (cyc >= 1 && cyc <= 4) drive(PORT_N, PORT_W, 1'b1); else idle_in(PORT_N);
      settle();
      checks++;
      if ({bus.o_input_grant[PORT_N], bus.o_input_grant[PORT_E]} !== {cyc == 4, cyc <= 3}
          || {bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
        errors++;
        $display("FAIL wormhole_c%0d grant=%b val=%b exp grant=%b val=%b", cyc, bus.o_input_grant, bus.o_output_val, exp_grant, exp_val);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_owner_stall();
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.i_en[PORT_S] = 1'b1;
      if (cyc <= 4) drive(PORT_C, PORT_S, cyc == 4); else idle_in(PORT_C);
      if (cyc == 1 || cyc == 2) bus.i_val[PORT_C] = 1'b0;
      if (cyc <= 5) drive(PORT_W, PORT_S, 1'b1);
      settle();
      checks++;
      if ({bus.o_input_grant[PORT_C], bus.o_input_grant[PORT_W], bus.o_output_val[PORT_S]}
            !== {cyc == 0 || cyc == 3 || cyc == 4, cyc == 5, cyc != 1 && cyc != 2}
          || {bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
        errors++;
        $display("FAIL owner_stall_c%0d grant=%b val=%b exp grant=%b val=%b", cyc, bus.o_input_grant, bus.o_output_val, exp_grant, exp_val);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_en_stall();
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(PORT_E, PORT_S, 1'b1);
      bus.i_en[PORT_S] = (cyc == 3);
      settle();
      checks++;
      if ({bus.o_output_sel[PORT_S*N +: N], bus.o_input_grant[PORT_E]} !== {5'b00100, cyc == 3}
          || {bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
        errors++;
        $display("FAIL en_stall_c%0d sel_s=%b grant=%b exp sel_s=00100 grant=%b", cyc, bus.o_output_sel[PORT_S*N +: N], bus.o_input_grant, exp_grant);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.i_en = '1;
    drive(PORT_S, PORT_N, 1'b1);
    settle();
    advance();
    idle_in(PORT_S);
    drive(PORT_E, PORT_N, 1'b0);
    drive(PORT_N, PORT_W, 1'b0);
    settle();
    checks++;
    if ({bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
      errors++;
      $display("FAIL midreset_lock grant=%b val=%b exp grant=%b val=%b", bus.o_input_grant, bus.o_output_val, exp_grant, exp_val);
    end
    advance();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== 35'd0) begin
      errors++;
      $display("FAIL midreset_async sel=%h grant=%b val=%b required all zero", bus.o_output_sel, bus.o_input_grant, bus.o_output_val);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(PORT_C, PORT_N, 1'b1);
    drive(PORT_E, PORT_N, 1'b1);
    settle();
    checks++;
    if ({bus.o_input_grant[PORT_C], bus.o_input_grant[PORT_E]} !== 2'b10
        || {bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
      errors++;
      $display("FAIL midreset_ptr0 grant=%b exp grant=%b", bus.o_input_grant, exp_grant);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) drive(i, int'($urandom_range(0, N - 1)), $urandom_range(0, 2) == 0);
        else idle_in(i);
      end
      for (int o = 0; o < N; o++) bus.i_en[o] = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if ({bus.o_output_sel, bus.o_input_grant, bus.o_output_val} !== {exp_sel, exp_grant, exp_val}) begin
        errors++;
        $display("FAIL random_c%0d sel=%h grant=%b val=%b exp sel=%h grant=%b val=%b", cyc, bus.o_output_sel, bus.o_input_grant, bus.o_output_val, exp_sel, exp_grant, exp_val);
      end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_owner_stall();
    test_en_stall();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
